cmd_arbiter_ctrl: RTL and testbench

CMD_ARBITER_CTRL -- requirements
Module: cmd_arbiter_ctrl

---
 rtl/cmd_arbiter_ctrl.sv | 134 +++++++++++++
 tb/tb_cmd_arbiter_ctrl.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/cmd_arbiter_ctrl.sv
// Round-robin arbiter that forwards commands from two requesters to the SD physical layer.
// It runs the REQ/ACK handshakes, captures the response and bounds each command with a watchdog.
module cmd_arbiter_ctrl #(
    parameter int WATCHDOG_CYCLES = 256,
    parameter int WD_WIDTH        = 9
) (
    input  logic        CLK_SD_card,
    input  logic        reset,
    input  logic        req_valid_a,
    input  logic        req_valid_b,
    input  logic [37:0] req_cmd_a,
    input  logic [37:0] req_cmd_b,
    output logic        done_a,
    output logic        done_b,
    output logic [37:0] resp_a,
    output logic [37:0] resp_b,
    output logic        timeout_a,
    output logic        timeout_b,
    output logic        busy,
    output logic        new_cmd,
    output logic [37:0] cmd_index_arg,
    output logic        REQ_out,
    input  logic        ACK_in,
    input  logic        REQ_in,
    output logic        ACK_out,
    input  logic [37:0] cmd_response,
    input  logic        physical_inactive
);

    typedef enum logic [2:0] {IDLE, ISSUE, WAIT_RESP, RELEASE, DONE} state_t;

    localparam logic [WD_WIDTH-1:0] WD_LAST = WD_WIDTH'(WATCHDOG_CYCLES - 1);
    localparam logic [WD_WIDTH-1:0] WD_MAX  = WD_WIDTH'(WATCHDOG_CYCLES);

    state_t              state;
    logic                rr;          // 0 = A has priority, 1 = B
    logic                owner;       // 0 = A, 1 = B
    logic                seen_active;
    logic                timed_out;
    logic [WD_WIDTH-1:0] wd_cnt;
    logic                grant_b;
    logic                wd_expired;

    // Contention goes to rr; a lone requester wins regardless of rr.
    assign grant_b    = (req_valid_a && req_valid_b) ? rr : req_valid_b;
    assign wd_expired = (wd_cnt >= WD_LAST);
    assign busy       = (state != IDLE);

    always_ff @(posedge CLK_SD_card or negedge reset) begin
        if (!reset) begin
            state         <= IDLE;
            rr            <= 1'b0;
            owner         <= 1'b0;
            seen_active   <= 1'b0;
            timed_out     <= 1'b0;
            wd_cnt        <= '0;
            new_cmd       <= 1'b0;
            REQ_out       <= 1'b0;
            ACK_out       <= 1'b0;
            done_a        <= 1'b0;
            done_b        <= 1'b0;
            timeout_a     <= 1'b0;
            timeout_b     <= 1'b0;
            cmd_index_arg <= '0;
            resp_a        <= '0;
            resp_b        <= '0;
        end else begin
            done_a    <= 1'b0;
            done_b    <= 1'b0;
            timeout_a <= 1'b0;
            timeout_b <= 1'b0;

            if (state != IDLE && !physical_inactive)
                seen_active <= 1'b1;
            if ((state == ISSUE || state == WAIT_RESP) && wd_cnt != WD_MAX)
                wd_cnt <= wd_cnt + WD_WIDTH'(1);

            case (state)
                IDLE: begin
                    if (physical_inactive && (req_valid_a || req_valid_b)) begin
                        owner         <= grant_b;
                        cmd_index_arg <= grant_b ? req_cmd_b : req_cmd_a;
                        seen_active   <= 1'b0;
                        timed_out     <= 1'b0;
                        wd_cnt        <= '0;
                        new_cmd       <= 1'b1;
                        REQ_out       <= 1'b1;
                        state         <= ISSUE;
                    end
                end
                ISSUE: begin
                    if (ACK_in) begin
                        new_cmd <= 1'b0;
                        REQ_out <= 1'b0;
                        state   <= WAIT_RESP;
                    end else if (wd_expired) begin
                        new_cmd   <= 1'b0;
                        REQ_out   <= 1'b0;
                        timed_out <= 1'b1;
                        state     <= DONE;
                    end
                end
                WAIT_RESP: begin
                    // A response presented together with the return to inactive still counts.
                    if (REQ_in) begin
                        if (owner) resp_b <= cmd_response;
                        else       resp_a <= cmd_response;
                        ACK_out <= 1'b1;
                        state   <= RELEASE;
                    end else if ((seen_active && physical_inactive) || wd_expired) begin
                        timed_out <= 1'b1;
                        state     <= DONE;
                    end
                end
                RELEASE: begin
                    if (!REQ_in) begin
                        ACK_out <= 1'b0;
                        state   <= DONE;
                    end
                end
                DONE: begin
                    done_a    <= !owner;
                    done_b    <= owner;
                    timeout_a <= !owner && timed_out;
                    timeout_b <= owner && timed_out;
                    rr        <= !owner;
                    state     <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_cmd_arbiter_ctrl.sv
// Bench for cmd_arbiter_ctrl: plays the physical layer and compares every completion
// against a transaction-level round-robin/response model.
module tb_cmd_arbiter_ctrl;

    logic        CLK_SD_card = 1'b0;
    logic        reset = 1'b0;
    logic        req_valid_a = 1'b0, req_valid_b = 1'b0;
    logic [37:0] req_cmd_a = '0, req_cmd_b = '0;
    logic        ACK_in = 1'b0, REQ_in = 1'b0, physical_inactive = 1'b1;
    logic [37:0] cmd_response = '0;

    logic        done_a, done_b, timeout_a, timeout_b, busy, new_cmd, REQ_out, ACK_out;
    logic [37:0] resp_a, resp_b, cmd_index_arg;
    logic        w_done_a, w_done_b, w_timeout_a, w_timeout_b, w_busy, w_new_cmd, w_REQ_out, w_ACK_out;
    logic [37:0] w_resp_a, w_resp_b, w_cmd_index_arg;

    cmd_arbiter_ctrl dut (
        .CLK_SD_card(CLK_SD_card), .reset(reset),
        .req_valid_a(req_valid_a), .req_valid_b(req_valid_b),
        .req_cmd_a(req_cmd_a), .req_cmd_b(req_cmd_b),
        .done_a(done_a), .done_b(done_b), .resp_a(resp_a), .resp_b(resp_b),
        .timeout_a(timeout_a), .timeout_b(timeout_b), .busy(busy),
        .new_cmd(new_cmd), .cmd_index_arg(cmd_index_arg),
        .REQ_out(REQ_out), .ACK_in(ACK_in), .REQ_in(REQ_in), .ACK_out(ACK_out),
        .cmd_response(cmd_response), .physical_inactive(physical_inactive)
    );

    cmd_arbiter_ctrl #(.WATCHDOG_CYCLES(16), .WD_WIDTH(5)) u_wd (
        .CLK_SD_card(CLK_SD_card), .reset(reset),
        .req_valid_a(req_valid_a), .req_valid_b(req_valid_b),
        .req_cmd_a(req_cmd_a), .req_cmd_b(req_cmd_b),
        .done_a(w_done_a), .done_b(w_done_b), .resp_a(w_resp_a), .resp_b(w_resp_b),
        .timeout_a(w_timeout_a), .timeout_b(w_timeout_b), .busy(w_busy),
        .new_cmd(w_new_cmd), .cmd_index_arg(w_cmd_index_arg),
        .REQ_out(w_REQ_out), .ACK_in(ACK_in), .REQ_in(REQ_in), .ACK_out(w_ACK_out),
        .cmd_response(cmd_response), .physical_inactive(physical_inactive)
    );

    always #5 CLK_SD_card = ~CLK_SD_card;

    int          n_vec = 0;
    int          n_bad = 0;
    logic        m_rr = 1'b0;
    logic [37:0] m_resp_a = '0, m_resp_b = '0;

    task automatic chk(input string tag, input logic [37:0] got, input logic [37:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK_SD_card);
        #1;
    endtask

    function automatic logic [37:0] rnd38();
        return 38'({$urandom, $urandom});
    endfunction

    // One full command: grant prediction, handshake, then either a response or an
    // inactive-without-response timeout.
    task automatic run_txn(input logic va, input logic vb, input logic [37:0] ca, input logic [37:0] cb,
                           input int ack_dly, input int rsp_dly, input int hold,
                           input bit to_kind, input logic [37:0] rsp, input bit drop);
        logic        side;
        logic [37:0] exp_cmd;
        side    = (va && vb) ? m_rr : vb;
        exp_cmd = side ? cb : ca;
        req_valid_a = va; req_valid_b = vb;
        req_cmd_a = ca; req_cmd_b = cb;
        physical_inactive = 1'b1;
        tick();
        chk("new_cmd_lat", 38'(new_cmd), 38'd1);
        chk("req_out", 38'(REQ_out), 38'd1);
        chk("busy", 38'(busy), 38'd1);
        chk("cmd_latch", cmd_index_arg, exp_cmd);
        chk("done_width", 38'(done_a | done_b), 38'd0);
        if (drop) begin
            if (side) begin req_valid_b = 1'b0; req_cmd_b = ~cb; end
            else      begin req_valid_a = 1'b0; req_cmd_a = ~ca; end
        end
        repeat (ack_dly) tick();
        ACK_in = 1'b1; physical_inactive = 1'b0;
        tick();
        ACK_in = 1'b0;
        chk("issue_drop", 38'({new_cmd, REQ_out}), 38'd0);
        chk("cmd_hold", cmd_index_arg, exp_cmd);
        repeat (rsp_dly) tick();
        if (!to_kind) begin
            REQ_in = 1'b1; cmd_response = rsp;
            physical_inactive = 1'($urandom_range(0, 1));
            tick();
            chk("ack_out_lat", 38'(ACK_out), 38'd1);
            for (int h = 0; h < hold; h++) begin
                tick();
                chk("ack_hold", 38'(ACK_out), 38'd1);
            end
            REQ_in = 1'b0; physical_inactive = 1'b1; cmd_response = rnd38();
            tick();
            chk("ack_drop", 38'(ACK_out), 38'd0);
            if (side) m_resp_b = rsp;
            else      m_resp_a = rsp;
        end else begin
            physical_inactive = 1'b1;
            tick();
        end
        chk("done_early", 38'(done_a | done_b), 38'd0);
        tick();
        chk("done_a", 38'(done_a), 38'(!side));
        chk("done_b", 38'(done_b), 38'(side));
        chk("timeout_a", 38'(timeout_a), 38'(!side && to_kind));
        chk("timeout_b", 38'(timeout_b), 38'(side && to_kind));
        chk("resp_a", resp_a, m_resp_a);
        chk("resp_b", resp_b, m_resp_b);
        m_rr = !side;
        req_valid_a = 1'b0; req_valid_b = 1'b0;
    endtask

    task automatic pulse_reset();
        reset = 1'b0;
        #2;
        reset = 1'b1;
        m_rr = 1'b0; m_resp_a = '0; m_resp_b = '0;
    endtask

    initial begin
        logic [37:0] ca, cb;
        int wd_hi, mn_hi, wd_done_at, mn_done_at;
        logic wd_to, mn_to;

        // Reset state
        #12;
        chk("rst_outs", 38'({new_cmd, REQ_out, ACK_out, busy, done_a, done_b, timeout_a, timeout_b}), 38'd0);
        chk("rst_cmd", cmd_index_arg, 38'd0);
        chk("rst_resp_a", resp_a, 38'd0);
        chk("rst_resp_b", resp_b, 38'd0);
        reset = 1'b1;
        tick();

        // Simultaneous requests after reset: A, then B, then A again
        run_txn(1, 1, 38'h01_11111111, 38'h02_22222222, 1, 1, 0, 0, 38'h01_AAAA0001, 0);
        run_txn(1, 1, 38'h01_11111111, 38'h02_22222222, 0, 2, 1, 0, 38'h02_BBBB0002, 0);
        run_txn(1, 1, 38'h03_33333333, 38'h04_44444444, 2, 0, 0, 0, 38'h03_CCCC0003, 0);

        // A only, echoed response
        run_txn(1, 0, 38'h08_000001AA, 38'h0, 2, 0, 0, 0, 38'h08_000001AA, 0);
        // B only, no response after 64 cycles of activity
        run_txn(0, 1, 38'h0, 38'h11_00000000, 0, 64, 0, 1, 38'h0, 0);
        // Response held 3 cycles in RELEASE
        run_txn(0, 1, 38'h0, 38'h12_12345678, 1, 1, 2, 0, 38'h12_87654321, 0);

        for (int i = 0; i < 30; i++) begin
            logic va, vb;
            va = 1'($urandom_range(0, 1));
            vb = 1'($urandom_range(0, 1));
            if (!va && !vb) va = 1'b1;
            ca = rnd38(); cb = rnd38();
            if (ca == cb) cb = ~cb;
            run_txn(va, vb, ca, cb, $urandom_range(0, 3), $urandom_range(0, 4), $urandom_range(0, 3),
                    ($urandom_range(0, 3) == 0), rnd38(), 1'($urandom_range(0, 1)));
        end

        // Request withdrawn while the physical layer is busy: nothing issued
        physical_inactive = 1'b0; req_valid_a = 1'b1; req_cmd_a = 38'h05_55555555;
        repeat (3) tick();
        chk("no_grant_active", 38'({busy, new_cmd}), 38'd0);
        req_valid_a = 1'b0;
        tick();
        physical_inactive = 1'b1;
        repeat (2) tick();
        chk("no_grant_dropped", 38'({busy, new_cmd}), 38'd0);

        // Reset in WAIT_RESP
        req_valid_b = 1'b1; req_cmd_b = 38'h06_66666666;
        tick();
        ACK_in = 1'b1; physical_inactive = 1'b0;
        tick();
        ACK_in = 1'b0;
        tick();
        chk("pre_rst_busy", 38'(busy), 38'd1);
        #1 reset = 1'b0;
        #1;
        chk("mid_rst_outs", 38'({new_cmd, REQ_out, ACK_out, busy, done_a, done_b, timeout_a, timeout_b}), 38'd0);
        chk("mid_rst_cmd", cmd_index_arg, 38'd0);
        chk("mid_rst_resp", 38'(resp_a | resp_b), 38'd0);
        #1 reset = 1'b1;
        m_rr = 1'b0; m_resp_a = '0; m_resp_b = '0;
        tick();
        for (int c = 0; c < 4; c++) begin
            tick();
            chk("post_rst_wait", 38'({busy, done_a, done_b}), 38'd0);
        end
        run_txn(0, 1, 38'h0, 38'h06_66666666, 1, 1, 0, 0, 38'h06_00000066, 0);

        // Watchdog: ACK never comes; u_wd expires at 16, dut at 256
        pulse_reset();
        tick();
        req_valid_a = 1'b1; req_cmd_a = 38'h07_77777777; physical_inactive = 1'b1; ACK_in = 1'b0;
        tick();
        chk("wd_start", 38'({new_cmd, w_new_cmd}), 38'b11);
        req_valid_a = 1'b0;
        wd_hi = 1; mn_hi = 1; wd_done_at = -1; mn_done_at = -1; wd_to = 1'b0; mn_to = 1'b0;
        for (int c = 1; c < 300; c++) begin
            tick();
            if (w_new_cmd) wd_hi++;
            if (new_cmd) mn_hi++;
            if (w_done_a) begin wd_done_at = c; wd_to = w_timeout_a; end
            if (done_a) begin mn_done_at = c; mn_to = timeout_a; end
        end
        chk("wd16_new_cmd_cycles", 38'(wd_hi), 38'd16);
        chk("wd16_done_slot", 38'(wd_done_at), 38'd17);
        chk("wd16_timeout", 38'(wd_to), 38'd1);
        chk("wd256_new_cmd_cycles", 38'(mn_hi), 38'd256);
        chk("wd256_done_slot", 38'(mn_done_at), 38'd257);
        chk("wd256_timeout", 38'(mn_to), 38'd1);
        chk("wd_resp_a", resp_a, m_resp_a);
        chk("wd16_idle", 38'({w_busy, w_REQ_out, w_ACK_out, w_done_b, w_timeout_b}), 38'd0);
        chk("wd16_cmd", w_cmd_index_arg, 38'h07_77777777);
        chk("wd16_resp", w_resp_a | w_resp_b, 38'd0);
        chk("wd256_idle", 38'({busy, REQ_out, done_b}), 38'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
